// File: rtl/cpu_pkg.sv
// Shared core definitions: register-file geometry defaults and the types
// that decode and writeback use for register addresses and data words.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] regaddr_t;

endpackage

// File: rtl/regfile_2r1w_read_port.sv
// One registered read port. It selects the data source (array, same-cycle
// write bypass, or hardwired zero) and also produces the combinational hazard flag.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pend_bit,
  input  logic              we,
  input  logic              write_ok,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hazard
);

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              addr_match;
  logic              is_zero_reg;

  assign addr_match  = (waddr == raddr);
  assign is_zero_reg = ZERO_REG && (raddr == ADDR_W'(REG_ZERO));

  always_comb begin
    rdata_d = mem_data;
    if (is_zero_reg) begin
      rdata_d = '0;
    end else if (write_ok && addr_match) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ren) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

  // The raw write enable resolves the hazard: a write landing this cycle is
  // delivered through the bypass, so the reader need not stall.
  assign hazard = pend_bit & ~(we & addr_match);

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered reads, write bypass,
// optional hardwired-zero register 0 and a per-register pending scoreboard.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              hazard_a,
  output logic              hazard_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              write_ok;

  // Writes to a hardwired zero register are dropped everywhere, including bypass.
  assign write_ok = we && !(ZERO_REG && (waddr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Set after clear so a producer issued on the retiring edge stays pending.
  always_comb begin
    pend_d = pend_q;
    if (we) begin
      pend_d[waddr] = 1'b0;
    end
    if (pend_set) begin
      pend_d[pend_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      pend_d[REG_ZERO] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .ren     (ren),
    .raddr   (raddr_a),
    .mem_data(mem_q[raddr_a]),
    .pend_bit(pend_q[raddr_a]),
    .we      (we),
    .write_ok(write_ok),
    .waddr   (waddr),
    .wdata   (wdata),
    .rdata   (rdata_a),
    .hazard  (hazard_a)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .ren     (ren),
    .raddr   (raddr_b),
    .mem_data(mem_q[raddr_b]),
    .pend_bit(pend_q[raddr_b]),
    .we      (we),
    .write_ok(write_ok),
    .waddr   (waddr),
    .wdata   (wdata),
    .rdata   (rdata_b),
    .hazard  (hazard_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: default 32x32 with zero register, a
// ZERO_REG=0 twin sharing the same stimulus, and a 16-bit x 8-entry instance.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst, ren, we, pend_set;
  logic [4:0]  raddr_a, raddr_b, waddr, pend_addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b, z_rdata_a, z_rdata_b;
  logic        hazard_a, hazard_b, z_hazard_a, z_hazard_b;

  logic        s_ren, s_we, s_pend_set;
  logic [2:0]  s_raddr_a, s_raddr_b, s_waddr, s_pend_addr;
  logic [15:0] s_wdata, s_rdata_a, s_rdata_b;
  logic        s_hazard_a, s_hazard_b;

  int errors = 0;
  int checks = 0;
  logic [15:0] s_exp [8];

  always #5 clk = ~clk;

  regfile_2r1w dut (
    .clk(clk), .rst(rst), .ren(ren), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .we(we), .waddr(waddr), .wdata(wdata),
    .pend_set(pend_set), .pend_addr(pend_addr), .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  regfile_2r1w #(.ZERO_REG(1'b0)) dut_z0 (
    .clk(clk), .rst(rst), .ren(ren), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(z_rdata_a), .rdata_b(z_rdata_b), .we(we), .waddr(waddr), .wdata(wdata),
    .pend_set(pend_set), .pend_addr(pend_addr), .hazard_a(z_hazard_a), .hazard_b(z_hazard_b)
  );

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3)) dut_s (
    .clk(clk), .rst(rst), .ren(s_ren), .raddr_a(s_raddr_a), .raddr_b(s_raddr_b),
    .rdata_a(s_rdata_a), .rdata_b(s_rdata_b), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .pend_set(s_pend_set), .pend_addr(s_pend_addr), .hazard_a(s_hazard_a), .hazard_b(s_hazard_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
    $display("check %-16s got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    ren = 0; we = 0; pend_set = 0;
  endtask

  initial begin
    rst = 1; idle(); raddr_a = 0; raddr_b = 0; waddr = 0; wdata = 0; pend_addr = 0;
    s_ren = 0; s_we = 0; s_pend_set = 0; s_raddr_a = 0; s_raddr_b = 0;
    s_waddr = 0; s_wdata = 0; s_pend_addr = 0;
    tick(); tick();
    rst = 0;
    check("rst_rdata_a", rdata_a, 32'h0);
    check("rst_rdata_b", rdata_b, 32'h0);
    check("rst_hazard_a", {31'b0, hazard_a}, 32'h0);
    check("rst_hazard_b", {31'b0, hazard_b}, 32'h0);

    // Preload r5, then reset clears it
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; tick();
    idle(); ren = 1; raddr_a = 5; tick();
    check("preload_r5", rdata_a, 32'hDEADBEEF);
    rst = 1; tick(); rst = 0;
    check("rst_clears_out", rdata_a, 32'h0);
    ren = 1; raddr_a = 5; tick();
    check("rst_clears_r5", rdata_a, 32'h0);

    // Write then read, then hold with ren=0
    idle(); we = 1; waddr = 7; wdata = 32'h12345678; tick();
    idle(); ren = 1; raddr_a = 7; tick();
    check("wr_rd_r7", rdata_a, 32'h12345678);
    idle(); raddr_a = 5; tick(); tick();
    check("hold_r7", rdata_a, 32'h12345678);

    // Bypass on both ports over a stale value
    we = 1; waddr = 3; wdata = 32'h11111111; tick();
    we = 1; waddr = 3; wdata = 32'hA5A5A5A5; ren = 1; raddr_a = 3; raddr_b = 3; tick();
    check("bypass_a", rdata_a, 32'hA5A5A5A5);
    check("bypass_b", rdata_b, 32'hA5A5A5A5);
    idle(); ren = 1; tick();
    check("after_bypass_a", rdata_a, 32'hA5A5A5A5);

    // Zero register: suppressed write and bypass on dut, ordinary on dut_z0
    idle(); we = 1; waddr = 0; wdata = 32'hFFFFFFFF; ren = 1; raddr_a = 0; tick();
    check("zero_bypass", rdata_a, 32'h0);
    check("z0_bypass", z_rdata_a, 32'hFFFFFFFF);
    idle(); ren = 1; raddr_a = 0; tick();
    check("zero_read", rdata_a, 32'h0);
    check("z0_read", z_rdata_a, 32'hFFFFFFFF);
    idle(); pend_set = 1; pend_addr = 0; tick();
    idle(); raddr_a = 0; #1;
    check("zero_no_hazard", {31'b0, hazard_a}, 32'h0);
    check("z0_hazard", {31'b0, z_hazard_a}, 32'h1);

    // Scoreboard on r9
    idle(); pend_set = 1; pend_addr = 9; raddr_b = 9; raddr_a = 8; #1;
    check("pend_not_yet", {31'b0, hazard_b}, 32'h0);
    tick(); idle(); #1;
    check("hazard_b_set", {31'b0, hazard_b}, 32'h1);
    check("hazard_a_r8", {31'b0, hazard_a}, 32'h0);
    we = 1; waddr = 9; wdata = 32'h55; ren = 1; #1;
    check("hazard_b_resolved", {31'b0, hazard_b}, 32'h0);
    tick();
    check("sb_bypass_b", rdata_b, 32'h55);
    idle(); #1;
    check("pend_cleared", {31'b0, hazard_b}, 32'h0);
    we = 1; waddr = 9; wdata = 32'h66; pend_set = 1; pend_addr = 9; tick();
    idle(); #1;
    check("set_wins", {31'b0, hazard_b}, 32'h1);
    we = 1; waddr = 9; wdata = 32'h77; pend_set = 1; pend_addr = 10; tick();
    idle(); raddr_a = 10; #1;
    check("diff_clr_r9", {31'b0, hazard_b}, 32'h0);
    check("diff_set_r10", {31'b0, hazard_a}, 32'h1);

    // Reset mid-operation discards write, read and pending
    rst = 1; we = 1; waddr = 11; wdata = 32'hCAFEF00D; ren = 1; raddr_b = 9; tick();
    rst = 0; idle(); #1;
    check("midrst_rdata_b", rdata_b, 32'h0);
    check("midrst_hazard", {31'b0, hazard_a}, 32'h0);
    ren = 1; raddr_a = 11; tick();
    check("midrst_no_write", rdata_a, 32'h0);
    idle();

    // 16-bit x 8 instance: unique pattern per register, r0 hardwired to zero
    for (int i = 0; i < 8; i++) begin
      s_we = 1; s_waddr = 3'(i); s_wdata = 16'h1357 ^ (16'(i) * 16'h1111);
      s_exp[i] = (i == 0) ? 16'h0 : s_wdata;
      tick();
    end
    s_we = 0;
    for (int i = 0; i < 8; i++) begin
      s_ren = 1; s_raddr_a = 3'(i); s_raddr_b = 3'(7 - i); tick();
      check($sformatf("sweep_a_r%0d", i), {16'b0, s_rdata_a}, {16'b0, s_exp[i]});
      check($sformatf("sweep_b_r%0d", 7 - i), {16'b0, s_rdata_b}, {16'b0, s_exp[7 - i]});
    end
    s_ren = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
